// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_streamer
// Description : Read-side engine for an 8-bit synchronous FIFO. Issues read
//               strobes, captures the returned bytes into a 2-entry holding
//               buffer and presents them on a valid/ready stream framed with
//               m_last every PKT_LEN bytes. Supports orderly stop and a
//               discarding flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_streamer #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          flush,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STOP  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(PKT_LEN - 1);

  state_t        state;
  logic [DW-1:0] buf_data [2];
  logic [1:0]    occ;
  logic          rd_ptr;
  logic          wr_ptr;
  logic          inflight;
  logic [7:0]    byte_cnt;

  logic          pop;
  logic          push;
  logic          flush_entry;
  logic [2:0]    level;

  // Head of the holding buffer drives the stream; data and last are forced
  // low whenever nothing is presented so idle/reset outputs are clean.
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? buf_data[rd_ptr] : '0;
  assign m_last  = m_valid & (byte_cnt == LAST_CNT);
  assign busy    = (state != IDLE) | m_valid;

  // Flush is honoured from any active state; IDLE has nothing to discard.
  assign flush_entry = flush & ((state == RUN) | (state == STOP));

  // A captured byte is kept only while streaming; in FLUSH, or on the edge
  // that enters FLUSH, it is dropped along with the buffer.
  assign push = inflight & (state != FLUSH) & ~flush_entry;

  // Committed slots after this edge's pop: buffered bytes plus the one in flight.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // Read strobe: in RUN only when a slot is guaranteed for the returning byte.
  always_comb begin
    fifo_rd = 1'b0;
    case (state)
      RUN:     fifo_rd = ~fifo_empty & (level < 3'd2);
      FLUSH:   fifo_rd = ~fifo_empty;
      default: fifo_rd = 1'b0;
    endcase
  end

  // Control: state machine, buffer occupancy/pointers, in-flight flag and framing counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      occ      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
      byte_cnt <= 8'd0;
    end else begin
      // fifo_rd is never raised with the FIFO empty, so every strobe is a read.
      inflight <= fifo_rd;

      if (flush_entry) begin
        occ      <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        byte_cnt <= 8'd0;
      end else begin
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr   <= ~rd_ptr;
          byte_cnt <= (byte_cnt == LAST_CNT) ? 8'd0 : byte_cnt + 8'd1;
        end
        occ <= occ + {1'b0, push} - {1'b0, pop};
      end

      case (state)
        IDLE: begin
          if (enable & ~flush) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state <= FLUSH;
          end else if (~enable) begin
            state <= STOP;
          end
        end
        STOP: begin
          // Flush wins over enable; re-enable resumes directly without
          // passing through IDLE.
          if (flush) begin
            state <= FLUSH;
          end else if (enable) begin
            state <= RUN;
          end else if ((occ == 2'd0) & ~inflight) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (~flush & fifo_empty & ~inflight) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding buffer storage; written with the byte returned by the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= fifo_dout;
    end
  end

endmodule
`default_nettype wire
